// File: rtl/toom8_pointwise_sched.sv
// toom8_pointwise_sched: issues the 15 Toom-8 pointwise products through one shared pipelined
// multiplier, tracks credits and returned products, and signals completion to interpolation.
module toom8_pointwise_sched #(
    parameter int NUM_POINTS      = 15,
    parameter int IDX_W           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    output logic             mul_issue_valid,
    input  logic             mul_issue_ready,
    output logic [IDX_W-1:0] mul_issue_idx,
    input  logic             mul_rsp_valid,
    input  logic [IDX_W-1:0] mul_rsp_idx,
    output logic             res_we,
    output logic [IDX_W-1:0] res_waddr,
    output logic [2:0]       outstanding,
    output logic             busy,
    output logic             done,
    output logic             err_unexp
);
    localparam int               MW    = 2 ** IDX_W;
    localparam logic [2:0]       MAX_O = 3'(MAX_OUTSTANDING);
    localparam logic [IDX_W:0]   NP    = (IDX_W + 1)'(NUM_POINTS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_POINTS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]      issue_ptr;
    logic [NUM_POINTS-1:0] ret_mask;
    logic [MW-1:0]         mask_ext;
    logic [IDX_W:0]        ptr_eff;
    logic                  fire, acc, unexp, last_fire, start_acc, active;

    assign active    = (state == ISSUE) || (state == DRAIN);
    assign fire      = mul_issue_valid && mul_issue_ready;
    assign last_fire = fire && (issue_ptr == LAST);
    assign start_acc = start_valid && start_ready;
    assign mask_ext  = MW'(ret_mask);
    // A response may refer to the index being issued in the same cycle.
    assign ptr_eff   = {1'b0, issue_ptr} + {{IDX_W{1'b0}}, fire};
    assign acc       = mul_rsp_valid && active && ({1'b0, mul_rsp_idx} < NP)
                       && ({1'b0, mul_rsp_idx} < ptr_eff) && !mask_ext[mul_rsp_idx];
    assign unexp     = mul_rsp_valid && !acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_valid ? ISSUE : IDLE;
            ISSUE:   state_nxt = last_fire ? DRAIN : ISSUE;
            DRAIN:   state_nxt = &ret_mask ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ready     = state == IDLE;
        busy            = active;
        done            = state == DONE;
        mul_issue_valid = (state == ISSUE) && (outstanding < MAX_O);
        mul_issue_idx   = issue_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_ptr   <= '0;
            ret_mask    <= '0;
            outstanding <= '0;
            res_we      <= 1'b0;
            res_waddr   <= '0;
            err_unexp   <= 1'b0;
        end else begin
            res_we <= acc;
            if (acc) res_waddr <= mul_rsp_idx;
            if (start_acc) begin
                issue_ptr   <= '0;
                ret_mask    <= '0;
                outstanding <= '0;
                err_unexp   <= 1'b0;
            end else begin
                if (fire) issue_ptr <= issue_ptr + 1'b1;
                if (acc) ret_mask <= ret_mask | (NUM_POINTS'(1) << mul_rsp_idx);
                if (fire && !acc) outstanding <= outstanding + 3'd1;
                else if (!fire && acc) outstanding <= outstanding - 3'd1;
                if (unexp) err_unexp <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_toom8_pointwise_sched.sv
// tb_toom8_pointwise_sched: directed checks of issue order, credits, backpressure,
// out-of-order and unexpected responses, completion and reset.
module tb_toom8_pointwise_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid, start_ready;
    logic       mul_issue_valid, mul_issue_ready;
    logic [3:0] mul_issue_idx;
    logic       mul_rsp_valid;
    logic [3:0] mul_rsp_idx;
    logic       res_we;
    logic [3:0] res_waddr;
    logic [2:0] outstanding;
    logic       busy, done, err_unexp;

    toom8_pointwise_sched dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .mul_issue_valid(mul_issue_valid), .mul_issue_ready(mul_issue_ready),
        .mul_issue_idx(mul_issue_idx),
        .mul_rsp_valid(mul_rsp_valid), .mul_rsp_idx(mul_rsp_idx),
        .res_we(res_we), .res_waddr(res_waddr), .outstanding(outstanding),
        .busy(busy), .done(done), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, lat = 4, max_out = 0, done_cyc = -1, last_we_cyc = -1;
    bit auto_rsp = 1'b0;
    int pend_idx[$], pend_due[$], issued[$], written[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: optional model multiplier drives responses, outputs sampled mid-cycle.
    task automatic step();
        if (auto_rsp) begin
            mul_rsp_valid = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mul_rsp_valid = 1'b1;
                mul_rsp_idx   = 4'(pend_idx[0]);
                void'(pend_idx.pop_front());
                void'(pend_due.pop_front());
            end
        end
        #4;
        if (mul_issue_valid && mul_issue_ready) begin
            issued.push_back(int'(mul_issue_idx));
            pend_idx.push_back(int'(mul_issue_idx));
            pend_due.push_back(cyc + lat);
        end
        if (res_we) begin
            written.push_back(int'(res_waddr));
            last_we_cyc = cyc;
        end
        if (done) done_cyc = cyc;
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_job();
        issued.delete(); written.delete(); pend_idx.delete(); pend_due.delete();
        max_out = 0; done_cyc = -1; last_we_cyc = -1;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        for (int i = 0; i < 300 && done_cyc < 0; i++) step();
        chk({tag, "_done_seen"}, done_cyc >= 0, 1);
        chk({tag, "_done_after_we"}, done_cyc, last_we_cyc + 1);
        chk({tag, "_writes"}, written.size(), 15);
    endtask

    task automatic rsp(input int idx);
        mul_rsp_valid = 1'b1;
        mul_rsp_idx   = 4'(idx);
        step();
        mul_rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; mul_issue_ready = 1'b0;
        mul_rsp_valid = 1'b0; mul_rsp_idx = '0;
        #3;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Full in-order job, 4-cycle multiplier
        auto_rsp = 1'b1; mul_issue_ready = 1'b1;
        start_job();
        chk("t2_first_valid", mul_issue_valid, 1);
        chk("t2_busy", busy, 1);
        run_to_done("t2");
        chk("t2_issue_count", issued.size(), 15);
        for (int i = 0; i < 15 && i < issued.size(); i++) chk($sformatf("t2_issue%0d", i), issued[i], i);
        for (int i = 0; i < 15 && i < written.size(); i++) chk($sformatf("t2_waddr%0d", i), written[i], i);
        chk("t2_max_out_le4", max_out <= 4, 1);
        chk("t2_max_out", max_out, 4);
        chk("t2_start_ready_after", start_ready, 1);
        chk("t2_done_low_after", done, 0);

        // Backpressure at idx 7
        start_job();
        for (int i = 0; i < 50 && !(mul_issue_valid && mul_issue_idx == 4'd7); i++) step();
        chk("t3_reach7", mul_issue_idx, 7);
        mul_issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_hold_valid%0d", k), mul_issue_valid, 1);
            chk($sformatf("t3_hold_idx%0d", k), mul_issue_idx, 7);
            step();
        end
        mul_issue_ready = 1'b1;
        chk("t3_pre_fire_idx", mul_issue_idx, 7);
        step();
        chk("t3_post_fire_idx", mul_issue_idx, 8);
        run_to_done("t3");

        // Out-of-order return of the first batch
        auto_rsp = 1'b0;
        start_job();
        for (int k = 0; k < 4; k++) step();
        chk("t4_out_full", outstanding, 4);
        chk("t4_valid_blocked", mul_issue_valid, 0);
        mul_issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rsp(3 - k);
            chk($sformatf("t4_we%0d", k), res_we, 1);
            chk($sformatf("t4_waddr%0d", k), res_waddr, 3 - k);
            chk($sformatf("t4_out%0d", k), outstanding, 3 - k);
            chk($sformatf("t4_nodone%0d", k), done, 0);
        end
        pend_idx.delete(); pend_due.delete();
        auto_rsp = 1'b1; mul_issue_ready = 1'b1;
        run_to_done("t4");
        chk("t4_last_waddr", written[written.size()-1], 14);

        // Duplicate and out-of-range responses
        auto_rsp = 1'b0;
        start_job();
        for (int k = 0; k < 4; k++) step();
        mul_issue_ready = 1'b0;
        rsp(3);
        chk("t5_first3_we", res_we, 1);
        chk("t5_err_clean", err_unexp, 0);
        rsp(3);
        chk("t5_dup_we", res_we, 0);
        chk("t5_dup_out", outstanding, 3);
        chk("t5_dup_err", err_unexp, 1);
        rsp(15);
        chk("t5_oor_we", res_we, 0);
        chk("t5_oor_out", outstanding, 3);
        pend_idx.delete(); pend_due.delete();
        for (int k = 0; k < 3; k++) begin pend_idx.push_back(k); pend_due.push_back(cyc); end
        auto_rsp = 1'b1; mul_issue_ready = 1'b1;
        run_to_done("t5");
        chk("t5_err_sticky", err_unexp, 1);

        // Credit limit, simultaneous fire+response, start ignored while busy
        auto_rsp = 1'b0;
        start_job();
        chk("t6_err_cleared", err_unexp, 0);
        chk("t6_out0", outstanding, 0);
        for (int k = 0; k < 4; k++) step();
        chk("t6_out4", outstanding, 4);
        chk("t6_valid_low", mul_issue_valid, 0);
        start_valid = 1'b1;
        chk("t6_start_ready", start_ready, 0);
        step();
        start_valid = 1'b0;
        chk("t6_out_hold4", outstanding, 4);
        chk("t6_busy", busy, 1);
        chk("t6_idx_hold", mul_issue_idx, 4);
        mul_issue_ready = 1'b0;
        rsp(0);
        chk("t6_out3", outstanding, 3);
        mul_issue_ready = 1'b1;
        chk("t6_valid_again", mul_issue_valid, 1);
        rsp(1);
        chk("t6_simul_out", outstanding, 3);
        chk("t6_simul_idx", mul_issue_idx, 5);
        chk("t6_simul_we", res_we, 1);

        // Asynchronous reset mid-job
        rst_n = 1'b0;
        #1;
        chk("t1_start_ready", start_ready, 1);
        chk("t1_valid", mul_issue_valid, 0);
        chk("t1_we", res_we, 0);
        chk("t1_done", done, 0);
        chk("t1_busy", busy, 0);
        chk("t1_err", err_unexp, 0);
        chk("t1_out", outstanding, 0);
        chk("t1_idx", mul_issue_idx, 0);
        #1;
        rst_n = 1'b1;
        step();
        chk("t1_idle_after", start_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
